// File: rtl/sobel_window_3x3.sv
// Sliding 3x3 window builder for the RGB444 camera stream, feeding the Sobel kernel.
// Optional macro WIN_COORD_EN adds out_x/out_y ports carrying the window centre.
module sobel_window_3x3 #(
  parameter int PIX_W      = 12,
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PIX_W-1:0]              in_pixel,
  input  logic                          in_valid,
  input  logic                          in_sof,
  output logic [PIX_W-1:0]              out_lu,
  output logic [PIX_W-1:0]              out_lm,
  output logic [PIX_W-1:0]              out_ld,
  output logic [PIX_W-1:0]              out_mu,
  output logic [PIX_W-1:0]              out_mm,
  output logic [PIX_W-1:0]              out_md,
  output logic [PIX_W-1:0]              out_ru,
  output logic [PIX_W-1:0]              out_rm,
  output logic [PIX_W-1:0]              out_rd,
`ifdef WIN_COORD_EN
  output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_y,
`endif
  output logic                          out_valid,
  output logic                          out_eof
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT + 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [YW-1:0] Y_END  = YW'(IMG_HEIGHT);

  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic             r_frameActive;

  logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] r_lb2 [IMG_WIDTH];

  logic [PIX_W-1:0] r_colMu, r_colMm, r_colMd;
  logic [PIX_W-1:0] r_colRu, r_colRm, r_colRd;

  logic             w_accept;
  logic [XW-1:0]    w_x;
  logic [YW-1:0]    w_y;
  logic [PIX_W-1:0] w_a;
  logic [PIX_W-1:0] w_b;
  logic             w_window;
  logic             w_lineEnd;

  // A start-of-frame pixel is always taken as (0,0), even in the middle of a frame.
  assign w_accept  = in_valid & (in_sof | (r_frameActive & (r_y < Y_END)));
  assign w_x       = in_sof ? '0 : r_x;
  assign w_y       = in_sof ? '0 : r_y;
  assign w_a       = r_lb1[w_x];
  assign w_b       = r_lb2[w_x];
  assign w_lineEnd = (w_x == X_LAST);
  assign w_window  = w_accept & (w_x >= XW'(2)) & (w_y >= YW'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x           <= '0;
      r_y           <= '0;
      r_frameActive <= 1'b0;
    end else if (w_accept) begin
      if (w_lineEnd) begin
        r_x           <= '0;
        r_y           <= w_y + YW'(1);
        r_frameActive <= (w_y != Y_LAST);
      end else begin
        r_x           <= w_x + XW'(1);
        r_y           <= w_y;
        r_frameActive <= 1'b1;
      end
    end
  end

  // Line buffers and column shift are never cleared; stale content is masked by the x>=2, y>=2 gate.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[w_x] <= in_pixel;
      r_lb2[w_x] <= w_a;
      r_colMu    <= r_colRu;
      r_colMm    <= r_colRm;
      r_colMd    <= r_colRd;
      r_colRu    <= w_b;
      r_colRm    <= w_a;
      r_colRd    <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_lu    <= '0;
      out_lm    <= '0;
      out_ld    <= '0;
      out_mu    <= '0;
      out_mm    <= '0;
      out_md    <= '0;
      out_ru    <= '0;
      out_rm    <= '0;
      out_rd    <= '0;
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_valid <= w_window;
      out_eof   <= w_window & w_lineEnd & (w_y == Y_LAST);
      if (w_window) begin
        out_lu <= r_colMu;
        out_lm <= r_colMm;
        out_ld <= r_colMd;
        out_mu <= r_colRu;
        out_mm <= r_colRm;
        out_md <= r_colRd;
        out_ru <= w_b;
        out_rm <= w_a;
        out_rd <= in_pixel;
      end
    end
  end

`ifdef WIN_COORD_EN
  localparam int OYW = $clog2(IMG_HEIGHT);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_x <= '0;
      out_y <= '0;
    end else if (w_window) begin
      out_x <= w_x - XW'(1);
      out_y <= OYW'(w_y - YW'(1));
    end
  end
`else
  // Centre coordinates are not exported in this build.
`endif

endmodule
